// File: rtl/latency_ram_if.sv
// Single-port memory handshake shared by initiators and backing stores.
// The initiator (master) drives addr/din/re/we; the memory (slave) answers with dout/ready.
interface latency_ram_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int WORD_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] addr;
  logic [WORD_WIDTH-1:0] din;
  logic [WORD_WIDTH-1:0] dout;
  logic                  re;
  logic                  we;
  logic                  ready;

  modport master (output addr, din, re, we, input dout, ready);
  modport slave  (input addr, din, re, we, output dout, ready);
endinterface

// File: rtl/latency_ram.sv
// Memory responder with independent read/write latencies, request counters
// and a sticky flag for initiator protocol violations.
module latency_ram #(
  parameter int ADDR_WIDTH    = 64,
  parameter int WORD_WIDTH    = 64,
  parameter int DEPTH_BITS    = 10,
  parameter int READ_LATENCY  = 4,
  parameter int WRITE_LATENCY = 4
) (
  input  logic                clk,
  input  logic                rst,
  latency_ram_if.slave        bus,
  output logic [31:0]         read_count_o,
  output logic [31:0]         write_count_o,
  output logic                err_o
);

  typedef enum logic [1:0] {IDLE, BUSY_R, BUSY_W} state_e;

  state_e                state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [31:0]           rdCount_q, rdCount_d;
  logic [31:0]           wrCount_q, wrCount_d;
  logic [WORD_WIDTH-1:0] dout_q, dout_d;
  logic [WORD_WIDTH-1:0] rdata_q;
  logic                  err_q, err_d;
  logic                  acceptRd, acceptWr;
  logic [DEPTH_BITS-1:0] idx;
  logic                  unusedAddrBits;

  logic [WORD_WIDTH-1:0] mem [2**DEPTH_BITS];

  // Upper address bits alias onto the same word.
  assign idx            = bus.addr[DEPTH_BITS-1:0];
  assign unusedAddrBits = ^bus.addr[ADDR_WIDTH-1:DEPTH_BITS];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rdCount_d = rdCount_q;
    wrCount_d = wrCount_q;
    dout_d    = dout_q;
    err_d     = err_q;
    acceptRd  = 1'b0;
    acceptWr  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.we) begin
          acceptWr  = 1'b1;
          err_d     = err_q | bus.re;
          cnt_d     = 8'(WRITE_LATENCY);
          state_d   = BUSY_W;
          wrCount_d = wrCount_q + 32'd1;
        end else if (bus.re) begin
          acceptRd  = 1'b1;
          cnt_d     = 8'(READ_LATENCY);
          state_d   = BUSY_R;
          rdCount_d = rdCount_q + 32'd1;
        end
      end
      default: begin
        // Requests while busy are dropped but remembered as a violation.
        cnt_d = cnt_q - 8'd1;
        if (bus.re || bus.we) err_d = 1'b1;
        if (cnt_q <= 8'd1) begin
          state_d = IDLE;
          if (state_q == BUSY_R) dout_d = rdata_q;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 8'd0;
      rdCount_q <= 32'd0;
      wrCount_q <= 32'd0;
      dout_q    <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rdCount_q <= rdCount_d;
      wrCount_q <= wrCount_d;
      dout_q    <= dout_d;
      err_q     <= err_d;
    end
  end

  // Storage is never cleared; writes commit on the accept edge.
  always_ff @(posedge clk) begin
    if (acceptWr && !rst) mem[idx] <= bus.din;
    if (acceptRd && !rst) rdata_q <= mem[idx];
  end

  assign bus.ready     = (state_q == IDLE);
  assign bus.dout      = dout_q;
  assign read_count_o  = rdCount_q;
  assign write_count_o = wrCount_q;
  assign err_o         = err_q;

endmodule

// File: doc/latency_ram.md
# latency_ram

Synthesizable memory responder with independently configurable read and write latency. It serves the same single-port addr/din/dout/re/we/ready handshake that cache, spm, split and combine use toward their backing store, and can replace ram at the bottom of any hierarchy. Benches use it to exercise initiator timing against slow, asymmetric memories. It also counts accepted requests and flags protocol violations by the initiator.

## Interface

- ADDR_WIDTH, 64: width of addr.
- WORD_WIDTH, 64: width of din/dout.
- DEPTH_BITS, 10: storage holds 2^DEPTH_BITS words, indexed by addr[DEPTH_BITS-1:0].
- READ_LATENCY, 4: cycles ready stays low after an accepted read; legal range 1..255.
- WRITE_LATENCY, 4: cycles ready stays low after an accepted write; legal range 1..255.

- clk  in  1  clock. All state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- addr  in  ADDR_WIDTH  word address, sampled on the accept edge.
- din  in  WORD_WIDTH  write data, sampled on the accept edge.
- dout  out  WORD_WIDTH  read data; valid while ready=1 after a read completes.
- re  in  1  read request.
- we  in  1  write request.
- ready  out  1  responder idle and able to accept a request.
- read_count  out  32  number of accepted reads; wraps modulo 2^32.
- write_count  out  32  number of accepted writes; wraps modulo 2^32.
- err  out  1  sticky protocol-violation flag.

## Operation

- States: IDLE, BUSY_R, BUSY_W. Down-counter cnt is 8 bits wide.
- IDLE with ready=1:
  - we=1: store din at index, load cnt=WRITE_LATENCY, go to BUSY_W, increment write_count.
  - re=1 and we=0: latch mem[index] into a data register, load cnt=READ_LATENCY, go to BUSY_R, increment read_count.
- re=1 and we=1 together: treated as a write, and err is set.
- BUSY_R / BUSY_W: cnt decrements each cycle. When cnt reaches 1, the next edge returns to IDLE; on a read, dout is driven from the data register at that edge.
- re or we asserted while not ready: the request is ignored (no memory or counter change) and err is set.
- dout holds the last read value through idle cycles and through writes. It changes only on read completion or reset.
- Address aliasing: upper address bits are ignored, so addr and addr + 2^DEPTH_BITS map to the same word.
- Write-then-read of the same address returns the new data; a write is committed at its accept edge.

## Timing

- Accept edge T: ready=0 from T until T+L, where L is the applicable latency. ready=1 again after edge T+L, so it is low for exactly L cycles.
- With L=1, ready drops for a single cycle, matching cache-hit timing.
- The earliest next request is at edge T+L+1; back-to-back throughput is one request per L+1 cycles.
- Read data is valid in the same cycle ready returns to 1.
- Reset values: ready=1, dout=0, read_count=0, write_count=0, err=0, state=IDLE, cnt=0. Memory contents are not cleared.
- Reset mid-operation: the pending transaction is abandoned and ready=1 the cycle after the rst edge. A write already committed at its accept edge stays in memory.
- Counters increment on the accept edge, not on completion.

## Test plan

- Reset, then write 64'h0123456789abcdef to address 1 with WRITE_LATENCY=4, then read address 1 → ready low for exactly 4 cycles on each access; dout=64'h0123456789abcdef when ready rises; write_count=1, read_count=1.
- Asymmetric latency (READ_LATENCY=7, WRITE_LATENCY=2): write 123 to address 259, then read 259 → ready low for 2 cycles, then 7 cycles; dout=123.
- Aliasing with DEPTH_BITS=8: write 5 to address 3, read address 259 → dout=5.
- Assert re while ready=0 in the middle of a write → no extra count and memory unchanged; err=1 and it stays set until rst.
- Assert re and we together with din=9 at address 10, then read 10 → dout=9; write_count=1, read_count=1 (from the later read); err=1.
- Assert rst two cycles into a 7-cycle read → ready=1, dout=0 and both counts 0 on the following cycle; a subsequent read of a previously written address returns the old data.
